// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } lsu_state_t;

  localparam logic        LANE_LO = 1'b0;
  localparam logic        LANE_HI = 1'b1;
  localparam int unsigned BYTE_W  = 8;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: extracts a byte with sign/zero extension and merges a byte
// into a word. Little-endian lanes; only DATA_W = 16 (two lanes) is supported.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  input  logic              lane,
  input  logic              sign_ext,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] merged_data
);

  logic [BYTE_W-1:0] sel_byte;

  // Select the addressed lane, extend it, and build the merged store word.
  always_comb begin
    sel_byte    = (lane == LANE_HI) ? word[2*BYTE_W-1:BYTE_W] : word[BYTE_W-1:0];
    ext_data    = {{(DATA_W-BYTE_W){sign_ext & sel_byte[BYTE_W-1]}}, sel_byte};
    merged_data = word;
    if (lane == LANE_HI) begin
      merged_data[2*BYTE_W-1:BYTE_W] = byte_in;
    end else begin
      merged_data[BYTE_W-1:0] = byte_in;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word and byte accesses to DataMemory.
// Byte stores are read-modify-write. Memory and response outputs depend only on
// the state register and request latches.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged_data;

  lsu_byte_lane #(
    .DATA_W(DATA_W)
  ) u_byte_lane (
    .word       (mem_read_data),
    .lane       (addr_q[0]),
    .sign_ext   (signed_q),
    .byte_in    (wdata_q[BYTE_W-1:0]),
    .ext_data   (ext_data),
    .merged_data(merged_data)
  );

  // Next-state and latch update logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    byte_d   = byte_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          write_d  = req_write;
          byte_d   = req_byte;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (!req_byte && req_addr[0]) begin
            // Misaligned word access: report without touching memory.
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_write && !req_byte) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (write_q) begin
          wdata_d = merged_data;
          state_d = WR;
        end else begin
          rdata_d = byte_q ? ext_data : mem_read_data;
          state_d = RESP;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state and latches only.
  always_comb begin
    req_ready      = (state_q == IDLE);
    mem_read       = (state_q == RD);
    mem_write      = (state_q == WR);
    mem_address    = '0;
    mem_write_data = '0;
    resp_valid     = (state_q == RESP);
    resp_rdata     = '0;
    resp_err       = 1'b0;
    if (state_q == RD || state_q == WR) begin
      mem_address = addr_q[ADDR_W:1];
    end
    if (state_q == WR) begin
      mem_write_data = wdata_q;
    end
    if (state_q == RESP) begin
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

endmodule
